// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic stage with a valid/ready stream
// interface and a multi-beat accumulate mode.
//
// Ports:
//   clk_in, rst_n_in             clock, async active-low reset
//   in_valid_in / in_ready_out   input beat handshake
//   a_in, b_in, op_in            operands and function select (8 functions)
//   acc_mode_in, last_in         start accumulate packet / final beat marker
//   out_valid_out / out_ready_in result handshake
//   result_out                   registered result
//   red_and/or/xor_out, zero_out reduction flags of result_out
//   beat_cnt_out                 saturating count of beats folded into result
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op_in,
  input  logic             acc_mode_in,
  input  logic             last_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [WIDTH-1:0] result_out,
  output logic             red_and_out,
  output logic             red_or_out,
  output logic             red_xor_out,
  output logic             zero_out,
  output logic [CNT_W-1:0] beat_cnt_out
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             red_and_q, red_and_d;
  logic             red_or_q, red_or_d;
  logic             red_xor_q, red_xor_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic [WIDTH-1:0] opnd_x;
  logic [WIDTH-1:0] fv;
  logic [CNT_W-1:0] cnt_inc;
  logic             load;
  logic [CNT_W-1:0] load_cnt;

  function automatic logic [WIDTH-1:0] fn(input logic [2:0] op,
                                          input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y);
    case (op)
      3'd0:    fn = x & y;
      3'd1:    fn = x | y;
      3'd2:    fn = x ^ y;
      3'd3:    fn = ~x;
      3'd4:    fn = ~y;
      3'd5:    fn = ~(x & y);
      3'd6:    fn = ~(x | y);
      default: fn = ~(x ^ y);
    endcase
  endfunction

  // Ready depends only on the output register and the consumer, never on
  // in_valid_in, so upstream can't form a combinational loop through us.
  assign in_ready_out = !out_valid_q || out_ready_in;
  assign accept       = in_valid_in && in_ready_out;

  // In ACCUM the running accumulator replaces operand A.
  assign opnd_x  = (state_q == ACCUM) ? acc_q : a_in;
  assign fv      = fn(op_in, opnd_x, b_in);
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      bcnt_q      <= '0;
      red_and_q   <= 1'b0;
      red_or_q    <= 1'b0;
      red_xor_q   <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      bcnt_q      <= bcnt_d;
      red_and_q   <= red_and_d;
      red_or_q    <= red_or_d;
      red_xor_q   <= red_xor_d;
      zero_q      <= zero_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && acc_mode_in && !last_in) state_d = ACCUM;
      ACCUM:   if (accept && last_in)                 state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    load_cnt = '0;
    if (accept) begin
      if (state_q == IDLE) begin
        if (acc_mode_in && !last_in) begin
          acc_d = fv;
          cnt_d = CNT_W'(1);
        end else begin
          load     = 1'b1;
          load_cnt = CNT_W'(1);
        end
      end else if (!last_in) begin
        acc_d = fv;
        cnt_d = cnt_inc;
      end else begin
        load     = 1'b1;
        load_cnt = cnt_inc;
        acc_d    = '0;
        cnt_d    = '0;
      end
    end

    // A load may coincide with the transfer of the previous result.
    out_valid_d = load || (out_valid_q && !out_ready_in);
    result_d    = result_q;
    bcnt_d      = bcnt_q;
    red_and_d   = red_and_q;
    red_or_d    = red_or_q;
    red_xor_d   = red_xor_q;
    zero_d      = zero_q;
    if (load) begin
      // Flags are registered alongside the result so they load atomically.
      result_d  = fv;
      bcnt_d    = load_cnt;
      red_and_d = &fv;
      red_or_d  = |fv;
      red_xor_d = ^fv;
      zero_d    = (fv == '0);
    end
  end

  assign out_valid_out = out_valid_q;
  assign result_out    = result_q;
  assign beat_cnt_out  = bcnt_q;
  assign red_and_out   = red_and_q;
  assign red_or_out    = red_or_q;
  assign red_xor_out   = red_xor_q;
  assign zero_out      = zero_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          in_valid_in, in_ready_out;
  logic [W-1:0]  a_in, b_in;
  logic [2:0]    op_in;
  logic          acc_mode_in, last_in;
  logic          out_valid_out, out_ready_in;
  logic [W-1:0]  result_out;
  logic          red_and_out, red_or_out, red_xor_out, zero_out;
  logic [CW-1:0] beat_cnt_out;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state: open packet beats and expected results in order
  logic [W-1:0] pk_a[$];
  logic [W-1:0] pk_b[$];
  logic [2:0]   pk_op[$];
  logic [W-1:0] exp_res[$];
  int           exp_cnt[$];

  logic [W-1:0] pt_tab [8];

  logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .in_valid_in(in_valid_in), .in_ready_out(in_ready_out),
    .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .acc_mode_in(acc_mode_in), .last_in(last_in),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .result_out(result_out),
    .red_and_out(red_and_out), .red_or_out(red_or_out),
    .red_xor_out(red_xor_out), .zero_out(zero_out),
    .beat_cnt_out(beat_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_f(input logic [2:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~x;
      3'd4: return ~y;
      3'd5: return ~(x & y);
      3'd6: return ~(x | y);
      default: return ~(x ^ y);
    endcase
  endfunction

  // fold the whole recorded packet: first beat uses A, later beats the running value
  task automatic close_packet();
    logic [W-1:0] v;
    int n;
    n = pk_a.size();
    v = ref_f(pk_op[0], pk_a[0], pk_b[0]);
    for (int i = 1; i < n; i++) v = ref_f(pk_op[i], v, pk_b[i]);
    exp_res.push_back(v);
    exp_cnt.push_back(n > CMAX ? CMAX : n);
    pk_a.delete(); pk_b.delete(); pk_op.delete();
  endtask

  task automatic model_clear();
    pk_a.delete(); pk_b.delete(); pk_op.delete();
    exp_res.delete(); exp_cnt.delete();
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    chk("in_ready", in_ready_out, (exp_res.size() == 0) || out_ready_in);
    chk("out_valid", out_valid_out, exp_res.size() != 0);
    if (exp_res.size() != 0) begin
      e = exp_res[0];
      chk("result", result_out, e);
      chk("beat_cnt", beat_cnt_out, exp_cnt[0]);
      chk("red_and", red_and_out, &e);
      chk("red_or", red_or_out, |e);
      chk("red_xor", red_xor_out, ^e);
      chk("zero", zero_out, e == 0);
    end
  endtask

  // one cycle: check at negedge, drive, advance the model at the rising edge
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic m, input logic l, input logic r);
    logic rdy, xfer;
    @(negedge clk_in);
    check_outputs();
    in_valid_in = v; a_in = a; b_in = b; op_in = op;
    acc_mode_in = m; last_in = l; out_ready_in = r;
    xfer = (exp_res.size() != 0) && r;
    rdy  = (exp_res.size() == 0) || r;
    @(posedge clk_in);
    if (xfer) begin
      void'(exp_res.pop_front());
      void'(exp_cnt.pop_front());
    end
    if (v && rdy) begin
      if (pk_a.size() == 0 && !(m && !l)) begin
        exp_res.push_back(ref_f(op, a, b));
        exp_cnt.push_back(1);
      end else begin
        pk_a.push_back(a); pk_b.push_back(b); pk_op.push_back(op);
        if (l) close_packet();
      end
    end
    #1;
  endtask

  task automatic idle_cycle();
    step(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    pt_tab[0] = 8'h24; pt_tab[1] = 8'hBD; pt_tab[2] = 8'h99; pt_tab[3] = 8'h5A;
    pt_tab[4] = 8'hC3; pt_tab[5] = 8'hDB; pt_tab[6] = 8'h42; pt_tab[7] = 8'h66;

    rst_n_in = 1'b0; in_valid_in = 0; a_in = 0; b_in = 0; op_in = 0;
    acc_mode_in = 0; last_in = 0; out_ready_in = 1;
    repeat (2) @(negedge clk_in);
    chk("rst_ready", in_ready_out, 1);
    chk("rst_valid", out_valid_out, 0);
    chk("rst_result", result_out, 0);
    chk("rst_cnt", beat_cnt_out, 0);
    chk("rst_flags", {red_and_out, red_or_out, red_xor_out, zero_out}, 0);
    rst_n_in = 1'b1;

    // pass-through, every op back to back, fixed literal results
    for (int op = 0; op < 8; op++) begin
      step(1'b1, 8'hA5, 8'h3C, 3'(op), 1'b0, 1'b0, 1'b1);
      chk("pt_valid", out_valid_out, 1);
      chk("pt_result", result_out, pt_tab[op]);
      chk("pt_cnt", beat_cnt_out, 1);
    end
    idle_cycle();

    // backpressure: result held, second beat refused until release
    step(1'b1, 8'hFF, 8'h0F, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hAA, 8'h55, 3'd1, 1'b0, 1'b0, 1'b0);
      chk("bp_hold", result_out, 8'h0F);
      chk("bp_ready", in_ready_out, 0);
    end
    step(1'b1, 8'hAA, 8'h55, 3'd1, 1'b0, 1'b0, 1'b1);
    chk("bp_second", result_out, 8'hFF);
    idle_cycle();
    idle_cycle();

    // accumulate XOR packet
    step(1'b1, 8'h0F, 8'hF0, 3'd2, 1'b1, 1'b0, 1'b1);
    chk("acc_noout1", out_valid_out, 0);
    step(1'b1, 8'h77, 8'hFF, 3'd2, 1'b0, 1'b0, 1'b1);
    chk("acc_noout2", out_valid_out, 0);
    step(1'b1, 8'h77, 8'h01, 3'd2, 1'b1, 1'b1, 1'b1);
    chk("acc_result", result_out, 8'h01);
    chk("acc_cnt", beat_cnt_out, 3);
    chk("acc_flags", {red_and_out, red_or_out, red_xor_out, zero_out}, 4'b0110);
    idle_cycle();

    // reset mid-packet, asserted mid-cycle
    step(1'b1, 8'h01, 8'h02, 3'd1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h04, 3'd1, 1'b0, 1'b0, 1'b1);
    @(negedge clk_in);
    in_valid_in = 0;
    #2 rst_n_in = 1'b0;
    #1;
    chk("mrst_ready", in_ready_out, 1);
    chk("mrst_valid", out_valid_out, 0);
    model_clear();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    idle_cycle();
    chk("mrst_nooutput", out_valid_out, 0);
    step(1'b1, 8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("mrst_pt", result_out, 8'h30);
    chk("mrst_cnt", beat_cnt_out, 1);
    idle_cycle();

    // counter saturation: 20-beat OR packet
    for (int i = 0; i < 20; i++)
      step(1'b1, 8'h00, 8'(1 << (i % 8)), 3'd1, 1'b1, (i == 19), 1'b1);
    chk("sat_result", result_out, 8'hFF);
    chk("sat_cnt", beat_cnt_out, CMAX);
    chk("sat_flags", {red_and_out, zero_out}, 2'b10);
    idle_cycle();

    // randomized traffic against the packet-level model
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom), 3'($urandom),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) < 7));
    // drain: close any open packet, then let results out
    step(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
    repeat (3) idle_cycle();
    chk("drain_empty", exp_res.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
